lspc_irq_ctrl: RTL and testbench

- Interrupt controller between the LSPC interrupt sources and the 68000 IPL/VPA pins.
- Latches three sources as pending levels:
  - raster timer IRQ (output of the timer block);
  - vertical-blank IRQ;
  - cold-boot/reset IRQ.
- Clears pending levels on 68k writes to the IRQ acknowledge register (0x3C000C).
- Presents the highest pending level on nIPL and answers the CPU interrupt-acknowledge cycle with an autovector (nVPA) handshake.

---
 rtl/lspc_irq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_lspc_irq_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lspc_irq_ctrl.sv
// LSPC interrupt controller: latches raster/vblank/boot IRQs, drives 68k nIPL and autovector nVPA.
// Optional build macro LSPC_IRQ_STATUS_READ_EN adds registered IRQ_STATUS and the LAST_IACK capture.
module lspc_irq_ctrl #(
    parameter bit          RESET_IRQ_PEND = 1'b1,
    parameter int unsigned VPA_RELEASE    = 1
) (
    input  logic       CLK_24M,
    input  logic       RESET,
    input  logic       TIMER_IRQ,
    input  logic       VBL_IRQ,
    input  logic       ACK_WR,
    input  logic [2:0] ACK_DATA,
    input  logic       IACK,
    input  logic [2:0] IACK_LEVEL,
    input  logic       nAS,
    output logic [2:0] nIPL,
    output logic       nVPA,
    output logic [2:0] IRQ_STATUS
);

    localparam int unsigned PEND_W = 3;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_VECTOR  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    logic              timer_irq_q, timer_irq_d;
    logic              vbl_irq_q, vbl_irq_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [PEND_W-1:0] pend_set, pend_clr;
    logic [1:0]        level;
    logic [2:0]        nipl_q, nipl_d;
    logic              nvpa_q, nvpa_d;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Edge detect and pending latch; pend is {L3,L2,L1}, ACK_DATA bit order is reversed.
    always_comb begin
        timer_irq_d = TIMER_IRQ;
        vbl_irq_d   = VBL_IRQ;
        pend_set    = {1'b0, TIMER_IRQ & ~timer_irq_q, VBL_IRQ & ~vbl_irq_q};
        pend_clr    = ACK_WR ? {ACK_DATA[0], ACK_DATA[1], ACK_DATA[2]} : 3'b000;
        pend_d      = pend_set | (pend_q & ~pend_clr);
    end

    always_comb begin
        level = 2'd0;
        if (pend_q[2]) begin
            level = 2'd3;
        end else if (pend_q[1]) begin
            level = 2'd2;
        end else if (pend_q[0]) begin
            level = 2'd1;
        end
        nipl_d = ~{1'b0, level};
    end

    always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET) begin
            timer_irq_q <= 1'b0;
            vbl_irq_q   <= 1'b0;
            pend_q      <= {RESET_IRQ_PEND, 2'b00};
            nipl_q      <= 3'b111;
        end else begin
            timer_irq_q <= timer_irq_d;
            vbl_irq_q   <= vbl_irq_d;
            pend_q      <= pend_d;
            nipl_q      <= nipl_d;
        end
    end

    // Autovector handshake; IACK seen during RELEASE is only honoured once back in IDLE.
    always_comb begin
        state_d = state_q;
        nvpa_d  = nvpa_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                nvpa_d = 1'b1;
                if (IACK && !nAS) begin
                    state_d = ST_VECTOR;
                    nvpa_d  = 1'b0;
                end
            end
            ST_VECTOR: begin
                nvpa_d = 1'b0;
                if (nAS) begin
                    state_d = ST_RELEASE;
                    nvpa_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE: begin
                nvpa_d = 1'b1;
                if (cnt_q >= CNT_W'(VPA_RELEASE - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                nvpa_d  = 1'b1;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            nvpa_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            nvpa_q  <= nvpa_d;
            cnt_q   <= cnt_d;
        end
    end

    assign nIPL = nipl_q;
    assign nVPA = nvpa_q;

`ifdef LSPC_IRQ_STATUS_READ_EN
    logic [PEND_W-1:0] status_q, status_d;
    logic [2:0]        last_iack_q, last_iack_d;
    logic              unused_last_iack;

    always_comb begin
        status_d    = pend_q;
        last_iack_d = last_iack_q;
        if (state_q == ST_IDLE && state_d == ST_VECTOR) begin
            last_iack_d = IACK_LEVEL;
        end
    end

    always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET) begin
            status_q    <= '0;
            last_iack_q <= 3'b000;
        end else begin
            status_q    <= status_d;
            last_iack_q <= last_iack_d;
        end
    end

    // LAST_IACK has no port; it exists for simulation visibility only.
    assign unused_last_iack = ^last_iack_q;
    assign IRQ_STATUS       = status_q;
`else
    logic unused_iack_level;

    assign unused_iack_level = ^IACK_LEVEL;
    assign IRQ_STATUS        = 3'b000;
`endif

endmodule

// File: tb/tb_lspc_irq_ctrl.sv
// Scoreboard bench for lspc_irq_ctrl: expectations queued with a due cycle, checked on the falling edge.
module tb_lspc_irq_ctrl;

    logic       clk;
    logic       rst;
    logic       timer_irq;
    logic       vbl_irq;
    logic       ack_wr;
    logic [2:0] ack_data;
    logic       iack;
    logic [2:0] iack_level;
    logic       n_as;
    logic [2:0] n_ipl;
    logic       n_vpa;
    logic [2:0] irq_status;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int         due;
        string      tag;
        logic [2:0] nipl;
        logic       nvpa;
        logic [2:0] status;
    } exp_t;

    exp_t sb[$];

    lspc_irq_ctrl dut (
        .CLK_24M    (clk),
        .RESET      (rst),
        .TIMER_IRQ  (timer_irq),
        .VBL_IRQ    (vbl_irq),
        .ACK_WR     (ack_wr),
        .ACK_DATA   (ack_data),
        .IACK       (iack),
        .IACK_LEVEL (iack_level),
        .nAS        (n_as),
        .nIPL       (n_ipl),
        .nVPA       (n_vpa),
        .IRQ_STATUS (irq_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b expected=%b (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Queue an expectation 'dly' rising edges after the current cycle.
    task automatic sb_push(input int dly, input string tag, input logic [2:0] nipl,
                           input logic nvpa, input logic [2:0] status);
        exp_t e;
        e.due  = cyc + dly;
        e.tag  = tag;
        e.nipl = nipl;
        e.nvpa = nvpa;
`ifdef LSPC_IRQ_STATUS_READ_EN
        e.status = status;
`else
        e.status = 3'b000;
`endif
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                chk({sb[i].tag, "_nipl"}, n_ipl, sb[i].nipl);
                chk({sb[i].tag, "_nvpa"}, {2'b00, n_vpa}, {2'b00, sb[i].nvpa});
                chk({sb[i].tag, "_status"}, irq_status, sb[i].status);
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse(input logic [2:0] data);
        ack_wr   = 1'b1;
        ack_data = data;
        tick();
        ack_wr   = 1'b0;
        ack_data = 3'b000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        timer_irq  = 1'b0;
        vbl_irq    = 1'b0;
        ack_wr     = 1'b0;
        ack_data   = 3'b000;
        iack       = 1'b0;
        iack_level = 3'b000;
        n_as       = 1'b1;
        tick();
        tick();

        // Reset state, then cold-boot level 3 after release
        sb_push(0, "rst", 3'b111, 1'b1, 3'b000);
        tick();
        rst = 1'b0;
        sb_push(1, "boot1", 3'b100, 1'b1, 3'b100);
        sb_push(3, "boot3", 3'b100, 1'b1, 3'b100);
        repeat (3) tick();
        sb_push(1, "ack3a", 3'b100, 1'b1, 3'b100);
        sb_push(2, "ack3b", 3'b111, 1'b1, 3'b000);
        ack_pulse(3'b001);
        repeat (2) tick();

        // VBL edge held high: one event, acked, no re-trigger
        vbl_irq = 1'b1;
        sb_push(1, "vbl1", 3'b111, 1'b1, 3'b000);
        sb_push(2, "vbl2", 3'b110, 1'b1, 3'b001);
        sb_push(9, "vbl_hold", 3'b110, 1'b1, 3'b001);
        repeat (10) tick();
        sb_push(2, "vbl_ack", 3'b111, 1'b1, 3'b000);
        sb_push(9, "vbl_noretrig", 3'b111, 1'b1, 3'b000);
        ack_pulse(3'b100);
        repeat (10) tick();
        vbl_irq = 1'b0;
        repeat (2) tick();

        // Timer and VBL together: priority, then ack in turn
        timer_irq = 1'b1;
        vbl_irq   = 1'b1;
        sb_push(2, "both", 3'b101, 1'b1, 3'b011);
        repeat (3) tick();
        sb_push(2, "ack_l2", 3'b110, 1'b1, 3'b001);
        ack_pulse(3'b010);
        repeat (2) tick();
        sb_push(2, "ack_l1", 3'b111, 1'b1, 3'b000);
        ack_pulse(3'b100);
        repeat (2) tick();
        timer_irq = 1'b0;
        vbl_irq   = 1'b0;
        tick();

        // Timer pulse, null acks, then set and ack colliding on L2
        timer_irq = 1'b1;
        tick();
        timer_irq = 1'b0;
        repeat (3) tick();
        sb_push(2, "ack_none", 3'b101, 1'b1, 3'b010);
        ack_pulse(3'b000);
        tick();
        sb_push(2, "ack_notpend", 3'b101, 1'b1, 3'b010);
        ack_pulse(3'b001);
        tick();
        timer_irq = 1'b1;
        sb_push(2, "setwins", 3'b101, 1'b1, 3'b010);
        sb_push(4, "setwins_hold", 3'b101, 1'b1, 3'b010);
        ack_pulse(3'b010);
        repeat (4) tick();
        timer_irq = 1'b0;
        sb_push(2, "l2_clr", 3'b111, 1'b1, 3'b000);
        ack_pulse(3'b010);
        repeat (2) tick();

        // IACK handshake with L1 pending; PEND must survive it
        vbl_irq = 1'b1;
        tick();
        vbl_irq = 1'b0;
        repeat (2) tick();
        iack       = 1'b1;
        n_as       = 1'b0;
        iack_level = 3'b001;
        sb_push(1, "iack_v1", 3'b110, 1'b0, 3'b001);
        sb_push(4, "iack_v4", 3'b110, 1'b0, 3'b001);
        repeat (4) tick();
        n_as = 1'b1;
        iack = 1'b0;
        sb_push(1, "iack_rel", 3'b110, 1'b1, 3'b001);
        tick();
        iack = 1'b1;
        n_as = 1'b0;
        sb_push(1, "iack_ignore", 3'b110, 1'b1, 3'b001);
        sb_push(2, "iack_retake", 3'b110, 1'b0, 3'b001);
        repeat (3) tick();

        // Asynchronous reset while in VECTOR
        rst = 1'b1;
        sb_push(0, "rst_async", 3'b111, 1'b1, 3'b000);
        tick();
        iack = 1'b0;
        n_as = 1'b1;
        tick();
        rst = 1'b0;
        sb_push(1, "rst_rel1", 3'b100, 1'b1, 3'b100);
        sb_push(3, "rst_rel3", 3'b100, 1'b1, 3'b100);
        repeat (4) tick();

        chk("sb_drain", 3'(sb.size()), 3'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
